rsa_decrypt_ctrl: RTL and testbench

Sequencing controller around the team's combinational RSA key-generation soft IP (N = P*Q, D = E^-1 mod (P-1)(Q-1)).
- Collects one key set and a burst of 8 ciphertext words.
- Registers N and D from the IP, then decrypts each word as M = C^D mod N with an iterative square-and-multiply engine.
- Streams the 8 plaintext words out in order.
- Top-level lab block; instantiates the key IP with WIDTH passed through.

---
 rtl/rsa_decrypt_ctrl.sv | 137 +++++++++++++
 tb/tb_rsa_decrypt_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_decrypt_ctrl.sv
// rsa_decrypt_ctrl: collects a key set and a ciphertext burst, decrypts each word by square-and-multiply, streams plaintext.
module rsa_keygen #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]   p,
  input  logic [WIDTH-1:0]   q,
  input  logic [2*WIDTH-1:0] e,
  output logic [2*WIDTH-1:0] n,
  output logic [2*WIDTH-1:0] d
);
  localparam int W2 = 2 * WIDTH;
  localparam int W4 = 4 * WIDTH;
  logic [W2-1:0] phi;
  always_comb begin
    n = W2'(p) * W2'(q);
    phi = W2'(p - WIDTH'(1)) * W2'(q - WIDTH'(1));
    d = '0;
    // descending scan leaves the smallest inverse in d
    for (int k = (1 << W2) - 1; k >= 1; k--)
      if (phi != '0 && (W4'(e) * W4'(k)) % W4'(phi) == W4'(1)) d = W2'(k);
  end
endmodule

module rsa_decrypt_ctrl #(
  parameter int WIDTH = 4,
  parameter int WORDS = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_p,
  input  logic [WIDTH-1:0]   in_q,
  input  logic [2*WIDTH-1:0] in_e,
  input  logic [2*WIDTH-1:0] in_c,
  output logic               out_valid,
  output logic [2*WIDTH-1:0] out_m
);
  localparam int W2 = 2 * WIDTH;
  localparam int W4 = 4 * WIDTH;
  localparam int IW = $clog2(WORDS);
  localparam int CW = $clog2(WORDS + 1);
  localparam int BW = $clog2(W2);
  typedef enum logic [1:0] {IDLE, LOAD, CALC, OUT} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] p_r, q_r;
  logic [W2-1:0] e_r, n_r, d_r, n_ip, d_ip, r, r_nx;
  logic [W4-1:0] t;
  logic [W2-1:0] cbuf [WORDS];
  logic [W2-1:0] mbuf [WORDS];
  logic [CW-1:0] wc;
  logic [IW-1:0] wi, oi;
  logic [BW-1:0] bi;

  rsa_keygen #(.WIDTH(WIDTH)) u_key (.p(p_r), .q(q_r), .e(e_r), .n(n_ip), .d(d_ip));

  always_comb begin
    t = (W4'(r) * W4'(r)) % W4'(n_r);
    r_nx = d_r[bi] ? W2'((t * W4'(cbuf[wi])) % W4'(n_r)) : W2'(t);
    state_nx = state;
    unique case (state)
      IDLE: state_nx = in_valid ? LOAD : IDLE;
      LOAD: state_nx = wc == CW'(WORDS) ? CALC : LOAD;
      CALC: state_nx = (bi == '0 && wi == IW'(WORDS - 1)) ? OUT : CALC;
      OUT:  state_nx = oi == IW'(WORDS - 1) ? IDLE : OUT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_m <= '0;
      p_r <= '0;
      q_r <= '0;
      e_r <= '0;
      n_r <= '0;
      d_r <= '0;
      r <= '0;
      wc <= '0;
      wi <= '0;
      oi <= '0;
      bi <= '0;
      for (int i = 0; i < WORDS; i++) begin
        cbuf[i] <= '0;
        mbuf[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          out_valid <= 1'b0;
          out_m <= '0;
          if (in_valid) begin
            p_r <= in_p;
            q_r <= in_q;
            e_r <= in_e;
            cbuf[0] <= in_c;
            wc <= CW'(1);
          end
        end
        LOAD: begin
          n_r <= n_ip;
          d_r <= d_ip;
          wi <= '0;
          bi <= BW'(W2 - 1);
          r <= W2'(1);
          if (in_valid) begin
            cbuf[wc[IW-1:0]] <= in_c;
            wc <= wc + CW'(1);
          end
        end
        CALC: begin
          if (bi == '0) begin
            mbuf[wi] <= r_nx;
            r <= W2'(1);
            bi <= BW'(W2 - 1);
            wi <= wi + IW'(1);
            if (wi == IW'(WORDS - 1)) begin
              out_valid <= 1'b1;
              out_m <= mbuf[0];
              oi <= IW'(1);
            end
          end else begin
            r <= r_nx;
            bi <= bi - BW'(1);
          end
        end
        OUT: begin
          out_m <= mbuf[oi];
          oi <= oi + IW'(1);
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rsa_decrypt_ctrl.sv
// tb_rsa_decrypt_ctrl: table-driven and scenario checks of the RSA decrypt controller against a plain-arithmetic model.
module tb_rsa_decrypt_ctrl;
  typedef struct packed {
    logic [3:0] p;
    logic [3:0] q;
    logic [7:0] e;
    logic [7:0][7:0] c;
    logic [7:0][7:0] m;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
  logic [3:0] in_p = '0, in_q = '0;
  logic [7:0] in_e = '0, in_c = '0;
  logic out_valid;
  logic [7:0] out_m;
  int checks = 0, errors = 0, cyc = 0;
  logic [7:0] got[$];
  int stamp[$];
  vec_t tbl[8];
  int la, lb, wait_n;

  rsa_decrypt_ctrl #(.WIDTH(4), .WORDS(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_p(in_p), .in_q(in_q),
    .in_e(in_e), .in_c(in_c), .out_valid(out_valid), .out_m(out_m)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid) begin
      got.push_back(out_m);
      stamp.push_back(cyc);
    end else begin
      checks++;
      if (out_m !== 8'd0) begin
        errors++;
        $display("FAIL idle_out_m: got %0d want 0 at cycle %0d", out_m, cyc);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic int gcd(input int a, input int b);
    while (b != 0) begin
      int t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic int model_d(input int p, input int q, input int e);
    int phi = (p - 1) * (q - 1);
    for (int k = 1; k < phi; k++) if ((e * k) % phi == 1) return k;
    return 1;
  endfunction

  function automatic int modpow(input int c, input int d, input int n);
    int r = 1;
    for (int i = 0; i < d; i++) r = (r * c) % n;
    return r;
  endfunction

  function automatic vec_t mk(input int p, input int q, input int e, input int c[8]);
    vec_t v;
    int d = model_d(p, q, e);
    v.p = 4'(p);
    v.q = 4'(q);
    v.e = 8'(e);
    for (int k = 0; k < 8; k++) begin
      v.c[k] = 8'(c[k]);
      v.m[k] = 8'(modpow(c[k], d, p * q));
    end
    return v;
  endfunction

  task automatic send(input vec_t v, output int last);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_p = k == 0 ? v.p : 4'($urandom);
      in_q = k == 0 ? v.q : 4'($urandom);
      in_e = k == 0 ? v.e : 8'($urandom);
      in_c = v.c[k];
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_c = 8'($urandom);
    last = cyc;
  endtask

  task automatic wait_beats(input int n);
    int w = 0;
    while (got.size() < n && w < 300) begin
      @(negedge clk);
      w++;
    end
  endtask

  task automatic collect(input vec_t v, input int last, input bit extra, input string tag);
    wait_beats(8);
    check($sformatf("%s_beat_count", tag), got.size() >= 8, 1);
    if (got.size() < 8) begin
      got.delete();
      stamp.delete();
      return;
    end
    check($sformatf("%s_latency", tag), stamp[0] - last, 65);
    check($sformatf("%s_contiguous", tag), stamp[7] - stamp[0], 7);
    for (int k = 0; k < 8; k++) check($sformatf("%s_m%0d", tag, k), got[k], v.m[k]);
    for (int k = 0; k < 8; k++) begin
      void'(got.pop_front());
      void'(stamp.pop_front());
    end
    if (extra) begin
      repeat (5) @(negedge clk);
      check($sformatf("%s_no_extra_beats", tag), got.size(), 0);
      got.delete();
      stamp.delete();
    end
  endtask

  initial begin
    int ca[8] = '{2, 0, 1, 14, 7, 4, 8, 11};
    int ea[8] = '{8, 0, 1, 14, 13, 4, 2, 11};
    int cb[8] = '{2, 3, 34, 0, 1, 6, 10, 12};
    int eb[8] = '{32, 33, 34, 0, 1, 6, 5, 17};
    int pr[6] = '{2, 3, 5, 7, 11, 13};
    int cr[8];
    tbl[0] = mk(3, 5, 3, ca);
    tbl[1] = mk(5, 7, 5, cb);
    for (int k = 0; k < 8; k++) begin
      tbl[0].m[k] = 8'(ea[k]);
      tbl[1].m[k] = 8'(eb[k]);
    end
    for (int i = 2; i < 8; i++) begin
      int a, b, p, q, phi, e, n;
      a = $urandom_range(0, 5);
      do b = $urandom_range(0, 5); while (b == a);
      p = pr[a];
      q = pr[b];
      n = p * q;
      phi = (p - 1) * (q - 1);
      do e = $urandom_range(1, 255); while (gcd(e, phi) != 1);
      if (i == 3) e = 1;
      for (int k = 0; k < 8; k++) cr[k] = $urandom_range(0, n - 1);
      if (i == 2) begin
        cr[0] = 0;
        cr[1] = 1;
        cr[2] = n - 1;
      end
      tbl[i] = mk(p, q, e, cr);
    end

    repeat (3) @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_m", out_m, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      send(tbl[i], la);
      collect(tbl[i], la, 1'b1, $sformatf("vec%0d", i));
    end

    send(tbl[0], la);
    wait_beats(8);
    send(tbl[1], lb);
    collect(tbl[0], la, 1'b0, "b2b_a");
    collect(tbl[1], lb, 1'b1, "b2b_b");

    send(tbl[2], la);
    repeat (21) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("calc_rst_out_valid", out_valid, 0);
    check("calc_rst_out_m", out_m, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("calc_rst_no_beats", got.size(), 0);
    got.delete();
    stamp.delete();
    send(tbl[3], la);
    collect(tbl[3], la, 1'b1, "after_calc_rst");

    send(tbl[4], la);
    wait_beats(3);
    check("out_rst_reached_beat3", got.size() >= 3, 1);
    #1 rst_n = 1'b0;
    #1;
    check("out_rst_out_valid", out_valid, 0);
    check("out_rst_out_m", out_m, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_n = got.size();
    repeat (20) @(negedge clk);
    check("out_rst_no_more_beats", got.size(), wait_n);
    got.delete();
    stamp.delete();
    send(tbl[5], la);
    collect(tbl[5], la, 1'b1, "after_out_rst");

    send(tbl[6], la);
    repeat (10) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_p = 4'($urandom);
      in_q = 4'($urandom);
      in_e = 8'($urandom);
      in_c = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_beats(2);
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      in_c = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    collect(tbl[6], la, 1'b1, "spurious");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
